instr_encoder: RTL
==================

Name: instr_encoder

Overview:
- Instruction encoder/loader: the encoding counterpart of the main control decoder.
- Accepts symbolic instruction requests over a valid/ready handshake and encodes them into 32-bit MIPS-Extended words.
- Writes the words sequentially into instruction memory through a registered write port.
- Used by the boot/self-test path to load programs without an external assembler.

Parameters:
- ADDR_W, 8, width of instruction-memory word address.
- DEPTH, 256, number of words writable per load session (1..2^ADDR_W).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  pulse: open a new load session at address 0.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid&in_ready at rising edge.
- in_kind  in  3  0=RTYPE, 1=LW, 2=SW, 3=BEQ, 4=RTR, 5=JRX, 6/7 illegal.
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register/shift fields.
- in_funct  in  6  funct field (RTYPE only).
- in_imm  in  16  immediate/offset (LW/SW/BEQ).
- imem_we  out  1  one-cycle write strobe.
- imem_addr  out  ADDR_W  write word address.
- imem_wdata  out  32  encoded instruction.
- count  out  ADDR_W+1  words written this session.
- full  out  1  count==DEPTH.
- err  out  1  sticky illegal-kind flag.

Behaviour:
- Clock/reset: one clock domain (clk). Reset is synchronous and active-high (reset).
- Reset values: state=IDLE; imem_we=0, imem_addr=0, imem_wdata=0, count=0, full=0, err=0.
- States and transitions:
  - IDLE: start -> RUN.
  - RUN: count reaches DEPTH -> FULL; illegal kind accepted -> ERR.
  - FULL and ERR: start -> RUN.
  - Any state: reset -> IDLE.
- in_ready = (state==RUN) & ~start. It is combinational from registered state, with no in_valid dependency.
- start (any state, incl. RUN mid-load): count<=0, err<=0, full<=0, state<=RUN. A coincident in_valid is not accepted that cycle.
- Encoding of a legal request accepted at edge N:
  - At N+1: imem_we=1, imem_addr=count[ADDR_W-1:0] as it was before N, imem_wdata=encoding. count increments at N.
  - Throughput is one word per cycle. imem_we is low in every cycle without a legal acceptance; imem_addr and imem_wdata hold their last values.
- Encoding per kind:
  - RTYPE: {6'b000000, rs, rt, rd, shamt, funct}.
  - LW: {6'b100011, rs, rt, imm}.
  - SW: {6'b101011, rs, rt, imm}.
  - BEQ: {6'b000100, rs, rt, imm}.
  - RTR: {6'b000000, rs, rt, rd, 5'b0, 6'b010110}; in_shamt and in_funct are ignored.
  - JRX: {6'b000000, rs, 15'b0, 6'b101101}; in_rt, in_rd, in_shamt and in_funct are ignored.
  - RTYPE passes in_funct verbatim, even if it equals 010110 or 101101.
- Illegal kind (6/7) accepted:
  - No write and no count change.
  - err<=1, state<=ERR; err stays set until start or reset.
- Full:
  - When the acceptance makes count==DEPTH, state<=FULL and full<=1 on the same edge.
  - The final write still appears at N+1. in_ready is low from then on.
- Reset mid-operation: a write pending for the next cycle is dropped (imem_we=0 after reset).

Test Plan:
- Reset, start, LW rs=2 rt=3 imm=0x0010 -> next cycle imem_we=1, addr=0, wdata=0x8C430010; count=1.
- Back-to-back, one per cycle:
  - SW rs=29 rt=8 imm=0xFFFC -> 0xAFA8FFFC @addr0.
  - BEQ rs=1 rt=2 imm=3 -> 0x10220003 @addr1.
  - RTYPE rs=1 rt=2 rd=3 shamt=0 funct=0x20 -> 0x00221820 @addr2.
  - Expect 3 consecutive imem_we cycles.
- RTR rs=4 rt=5 rd=6 with in_shamt=7, in_funct=0x3F -> 0x00853016.
- JRX rs=31 with in_rt=9 -> 0x03E0002D.
- DEPTH=4: 4 back-to-back requests -> addrs 0..3 written, full=1, in_ready=0; a 5th in_valid held 5 cycles -> no write. Then start -> count=0, full=0; next write at addr 0.
- Illegal kind=6 after 2 writes -> no write, err=1, in_ready=0, count=2. start coincident with in_valid -> not accepted that cycle, err=0. Next request is written at addr 0.

Source files
------------

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
//   Instruction encoder/loader. Accepts symbolic instruction requests over a
//   valid/ready handshake, encodes each into a 32-bit MIPS-Extended word and
//   writes the words sequentially into instruction memory through a registered
//   write port. A start pulse opens a new load session at address 0.
//
// Ports
//   clk            clock, all state updates on the rising edge
//   reset          synchronous active-high reset
//   start          pulse: open a new load session at address 0
//   in_valid       request valid
//   in_ready       request accepted when in_valid & in_ready at a rising edge
//   in_kind        0=RTYPE 1=LW 2=SW 3=BEQ 4=RTR 5=JRX, 6/7 illegal
//   in_rs/rt/rd    register fields
//   in_shamt       shift amount (RTYPE)
//   in_funct       funct field (RTYPE)
//   in_imm         immediate/offset (LW/SW/BEQ)
//   imem_we        one-cycle write strobe
//   imem_addr      write word address
//   imem_wdata     encoded instruction
//   count          words written this session
//   full           count == DEPTH
//   err            sticky illegal-kind flag
// -----------------------------------------------------------------------------
module instr_encoder #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_kind,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [5:0]        in_funct,
    input  logic [15:0]       in_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FULL = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    state_t              state_q, state_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                full_q, full_d;
    logic                err_q, err_d;

    logic                accept;
    logic                legal;
    logic [31:0]         enc_word;
    logic [ADDR_W:0]     count_inc;

    // Ready depends only on registered state and start, never on in_valid.
    assign in_ready  = (state_q == S_RUN) && !start;
    assign accept    = in_valid && in_ready;
    assign count_inc = count_q + 1'b1;

    // Encoder: pure function of the request fields.
    always_comb begin
        enc_word = 32'h0;
        legal    = 1'b1;
        unique case (in_kind)
            3'd0: enc_word = {6'b000000, in_rs, in_rt, in_rd, in_shamt, in_funct};
            3'd1: enc_word = {6'b100011, in_rs, in_rt, in_imm};
            3'd2: enc_word = {6'b101011, in_rs, in_rt, in_imm};
            3'd3: enc_word = {6'b000100, in_rs, in_rt, in_imm};
            // RTR and JRX are fixed-funct R-format forms; unused fields zeroed.
            3'd4: enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b010110};
            3'd5: enc_word = {6'b000000, in_rs, 15'b0, 6'b101101};
            default: legal = 1'b0;
        endcase
    end

    // Next-state and output-register logic.
    always_comb begin
        state_d = state_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        count_d = count_q;
        full_d  = full_q;
        err_d   = err_q;

        // start wins over everything in every state, including mid-load.
        if (start) begin
            state_d = S_RUN;
            count_d = '0;
            full_d  = 1'b0;
            err_d   = 1'b0;
        end else begin
            unique case (state_q)
                S_RUN: begin
                    if (accept) begin
                        if (legal) begin
                            we_d    = 1'b1;
                            addr_d  = count_q[ADDR_W-1:0];
                            wdata_d = enc_word;
                            count_d = count_inc;
                            if (count_inc == DEPTH_C) begin
                                state_d = S_FULL;
                                full_d  = 1'b1;
                            end
                        end else begin
                            state_d = S_ERR;
                            err_d   = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            count_q <= count_d;
            full_q  <= full_d;
            err_q   <= err_d;
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign count      = count_q;
    assign full       = full_q;
    assign err        = err_q;

endmodule
